// File: rtl/rom_port_arbiter.sv
// Two-port arbiter in front of a combinational instruction ROM. Fetch has fixed
// priority; a starvation counter forces one data grant after repeated losses.
module rom_port_arbiter #(
  parameter int ROM_WORDS    = 131,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             f_req,
  input  logic [30:0]      f_addr,
  output logic             f_gnt,
  output logic             f_rvalid,
  output logic [31:0]      f_rdata,
  input  logic             d_req,
  input  logic [30:0]      d_addr,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic [31:0]      d_rdata,
  output logic             rerr,
  output logic [30:0]      rom_addr,
  input  logic [31:0]      rom_data,
  output logic             dbg_mode,
  output logic [CNT_W-1:0] dbg_starve_cnt
);

  // Handshake: a port raises req with a stable addr; gnt is combinational in the
  // same cycle; the read returns as a one-cycle rvalid pulse on the next cycle.
  typedef enum logic {PRI_F = 1'b0, PRI_D = 1'b1} mode_t;

  localparam logic [CNT_W-1:0] LIM    = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] LIM_M1 = CNT_W'(STARVE_LIMIT - 1);
  localparam logic [28:0]      ROM_LIM = 29'(ROM_WORDS);

  mode_t            mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err;

  always_comb begin
    mode_d = mode_q;
    cnt_d  = cnt_q;
    f_gnt  = 1'b0;
    d_gnt  = 1'b0;
    if (!reset) begin
      if (mode_q == PRI_D) begin
        // Forced slot: D wins even against F; an absent D just hands the slot back to F.
        if (d_req) d_gnt = 1'b1;
        else if (f_req) f_gnt = 1'b1;
        mode_d = PRI_F;
      end else begin
        if (f_req) f_gnt = 1'b1;
        else if (d_req) d_gnt = 1'b1;
        if (f_req && d_req) begin
          if (cnt_q < LIM) cnt_d = cnt_q + 1'b1;
          if (cnt_q >= LIM_M1) mode_d = PRI_D;
        end
      end
      if (d_gnt) cnt_d = '0;
    end
  end

  assign rom_addr = f_gnt ? f_addr : (d_gnt ? d_addr : 31'd0);
  assign err      = (rom_addr[1:0] != 2'b00) || (rom_addr[30:2] >= ROM_LIM);

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q   <= PRI_F;
      cnt_q    <= '0;
      f_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      rerr     <= 1'b0;
      f_rdata  <= 32'd0;
      d_rdata  <= 32'd0;
    end else begin
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      f_rvalid <= f_gnt;
      d_rvalid <= d_gnt;
      rerr     <= (f_gnt || d_gnt) && err;
      if (f_gnt) f_rdata <= err ? 32'd0 : rom_data;
      if (d_gnt) d_rdata <= err ? 32'd0 : rom_data;
    end
  end

  assign dbg_mode       = mode_q;
  assign dbg_starve_cnt = cnt_q;

endmodule
